// File: rtl/controlsgs.sv
// controlsgs: shared EX/DM control-bundle typedef and NOP constant for all pipeline registers
package controlsgs_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } controlsgs_t;
  localparam controlsgs_t CTRL_NOP = '0;
endpackage

// File: rtl/ex_dm_register_if.sv
// ex_dm_register_if: EX-side inputs and DM-side outputs of the EX/DM register; EX_DM_VALID_EN adds valid bits
interface ex_dm_register_if #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
);
  import controlsgs_pkg::*;
  logic [XLEN-1:0]   e_alu_y, e_write_data, e_pc_plus4;
  logic [REG_AW-1:0] e_rd;
  controlsgs_t       e_controlsgs;
  logic [XLEN-1:0]   m_alu_y, m_write_data, m_pc_plus4;
  logic [REG_AW-1:0] m_rd;
  controlsgs_t       m_controlsgs;
`ifdef EX_DM_VALID_EN
  logic e_valid, m_valid;
`endif
  modport master (
`ifdef EX_DM_VALID_EN
    output e_valid, input m_valid,
`endif
    output e_alu_y, e_write_data, e_pc_plus4, e_rd, e_controlsgs,
    input  m_alu_y, m_write_data, m_pc_plus4, m_rd, m_controlsgs
  );
  modport slave (
`ifdef EX_DM_VALID_EN
    input e_valid, output m_valid,
`endif
    input  e_alu_y, e_write_data, e_pc_plus4, e_rd, e_controlsgs,
    output m_alu_y, m_write_data, m_pc_plus4, m_rd, m_controlsgs
  );
endinterface

// File: rtl/ex_dm_register_pipe_reg.sv
// pipe_reg: flop vector with async active-low reset, sync clear (priority) and enable
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // async reset wins, then clear to bubble, then capture, otherwise hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/ex_dm_register.sv
// ex_dm_register: EX->DM pipeline register with stall/flush; EX_DM_VALID_EN adds a valid bit gating controls
module ex_dm_register
  import controlsgs_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic flush,
  ex_dm_register_if.slave bus
);
  localparam int CW = $bits(controlsgs_t);
`ifdef EX_DM_VALID_EN
  localparam int W = 3 * XLEN + REG_AW + CW + 1;
  logic [W-1:0] d, q;
  controlsgs_t ctrl_q;
  assign d = {bus.e_valid, bus.e_alu_y, bus.e_write_data, bus.e_rd, bus.e_pc_plus4, bus.e_controlsgs};
  assign {bus.m_valid, bus.m_alu_y, bus.m_write_data, bus.m_rd, bus.m_pc_plus4, ctrl_q} = q;
  assign bus.m_controlsgs = bus.m_valid ? ctrl_q : CTRL_NOP;
`else
  localparam int W = 3 * XLEN + REG_AW + CW;
  logic [W-1:0] d, q;
  assign d = {bus.e_alu_y, bus.e_write_data, bus.e_rd, bus.e_pc_plus4, bus.e_controlsgs};
  assign {bus.m_alu_y, bus.m_write_data, bus.m_rd, bus.m_pc_plus4, bus.m_controlsgs} = q;
`endif
  pipe_reg #(.WIDTH(W)) u_reg (
    .clk(clk),
    .rst_n(reset),
    .clr(flush),
    .en(enable),
    .d(d),
    .q(q)
  );
endmodule

// File: tb/tb_ex_dm_register.sv
// tb_ex_dm_register: scoreboard bench for ex_dm_register; honours EX_DM_VALID_EN
module tb_ex_dm_register;
  import controlsgs_pkg::*;
  typedef struct packed {
    logic [31:0] y, wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    controlsgs_t c;
    logic        v;
  } exp_t;
  logic clk = 0, reset = 0, enable = 0, flush = 0;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t mdl = '0;
  logic in_v = 1;
  localparam controlsgs_t ALL = 10'h3FD;
  ex_dm_register_if #(.XLEN(32), .REG_AW(5)) bus ();
  ex_dm_register #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .flush(flush),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic en, input logic fl, input logic [31:0] y, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc, input controlsgs_t c, input logic v);
    enable = en;
    flush = fl;
    bus.e_alu_y = y;
    bus.e_write_data = wd;
    bus.e_rd = rd;
    bus.e_pc_plus4 = pc;
    bus.e_controlsgs = c;
    in_v = v;
`ifdef EX_DM_VALID_EN
    bus.e_valid = v;
`endif
  endtask
  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    cmp("alu_y", 64'(bus.m_alu_y), 64'(e.y));
    cmp("write_data", 64'(bus.m_write_data), 64'(e.wd));
    cmp("rd", 64'(bus.m_rd), 64'(e.rd));
    cmp("pc_plus4", 64'(bus.m_pc_plus4), 64'(e.pc));
`ifdef EX_DM_VALID_EN
    cmp("valid", 64'(bus.m_valid), 64'(e.v));
    cmp("controlsgs", 64'(bus.m_controlsgs), e.v ? 64'(e.c) : 64'd0);
`else
    cmp("controlsgs", 64'(bus.m_controlsgs), 64'(e.c));
`endif
  endtask
  task automatic step();
    if (!reset) mdl = '0;
    else if (flush) mdl = '0;
    else if (enable) mdl = '{bus.e_alu_y, bus.e_write_data, bus.e_rd, bus.e_pc_plus4, bus.e_controlsgs, in_v};
    q.push_back(mdl);
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    drive(1, 0, 32'h000000A1, 32'h11, 5'd3, 32'h104, ALL, 1);
    repeat (3) step();
    @(negedge clk);
    reset = 1;
    step();
    cmp("struct_bit_exact", 64'(bus.m_controlsgs), 64'(ALL));
    drive(0, 0, 32'hDEADBEEF, 32'h22, 5'd7, 32'h208, 10'h155, 1);
    repeat (3) step();
    drive(1, 0, 32'hDEADBEEF, 32'h22, 5'd7, 32'h208, 10'h155, 1);
    step();
    drive(1, 1, 32'h12345678, 32'h33, 5'd9, 32'h30C, ALL, 1);
    step();
    cmp("flush_reg_write", 64'(bus.m_controlsgs.reg_write), 64'd0);
    drive(1, 0, 32'hCAFEF00D, 32'h44, 5'd31, 32'h410, 10'h2AA, 1);
    step();
    drive(0, 1, 32'h0BADF00D, 32'h55, 5'd1, 32'h514, ALL, 1);
    step();
    drive(1, 0, 32'hA5A5A5A5, 32'h66, 5'd17, 32'h618, ALL, 1);
    step();
    #2;
    reset = 0;
    #1;
    mdl = '0;
    q.push_back(mdl);
    check();
    @(negedge clk);
    reset = 1;
    step();
`ifdef EX_DM_VALID_EN
    drive(1, 0, 32'h77777777, 32'h88, 5'd12, 32'h71C, ALL, 0);
    step();
    cmp("invalid_ctrl_gated", 64'(bus.m_controlsgs), 64'd0);
    drive(1, 0, 32'h77777777, 32'h88, 5'd12, 32'h71C, ALL, 1);
    step();
`endif
    for (int i = 0; i < 12; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom, $urandom,
            5'($urandom), $urandom, controlsgs_t'($urandom), 1'($urandom));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_dm_register.md
Name: ex_dm_register

Overview:
Pipeline register between the execute (EX) stage and the data-memory (DM) stage of the in-order core.
- Captures the ALU result, store data, destination register, PC+4 and the packed control-signal struct from EX on each enabled clock edge.
- Presents the captured values to DM.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- XLEN, 32, datapath width of alu_y, write_data and pc_plus4.
- REG_AW, 5, register-file address width of rd.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- enable  in  1  1 = capture EX inputs at the clock edge; 0 = hold (stall).
- flush  in  1  1 = load a bubble at the clock edge.
- e_alu_y  in  XLEN  ALU result from EX.
- e_write_data  in  XLEN  store data (rs2 after forwarding).
- e_rd  in  REG_AW  destination register index.
- e_pc_plus4  in  XLEN  PC+4, for link writeback.
- e_controlsgs  in  controlsgs_t  EX-stage control bundle.
- m_alu_y  out  XLEN  registered ALU result.
- m_write_data  out  XLEN  registered store data.
- m_rd  out  REG_AW  registered destination index.
- m_pc_plus4  out  XLEN  registered PC+4.
- m_controlsgs  out  controlsgs_t  registered control bundle.

Behaviour:
- All outputs are driven directly from flops. There is no combinational path from input to output.
- Reset (reset == 0) is asynchronous and takes priority over everything. Every output bit goes to 0, including all controlsgs_t fields (alu_op = 3'b000). Outputs stay 0 while reset is held low.
- Reset release is synchronous-safe: the first capture happens at the first rising edge after reset goes high.
- At a rising edge with reset high, priority is flush > enable > hold:
  - flush = 1: all m_* outputs load 0, whatever enable is. A zero control word is a NOP: no reg_write, no mem_write, no mem_read.
  - flush = 0, enable = 1: every m_* output takes its e_* input. Latency is exactly one cycle.
  - flush = 0, enable = 0: all m_* outputs hold their previous values.
- Struct transfer is bit-exact. All fields of controlsgs_t are copied with no decoding, so an all-ones struct with alu_op = 3'b101 appears unchanged at the output.
- No width conversion. Values are passed through without modification.
- Reset asserted mid-operation clears the outputs immediately, without waiting for a clock edge.
- Input X/Z values are only captured when enable = 1 and flush = 0.

Optional Feature:
Macro: EX_DM_VALID_EN
- Defined:
  - Adds input e_valid (1 bit) and output m_valid (1 bit).
  - m_valid resets to 0, is cleared by flush, and captures e_valid when enable = 1.
  - When m_valid = 0, m_controlsgs is forced to 0 at the output, so invalid slots can never write state.
- Undefined: neither port exists. The behaviour above is unchanged.

Decomposition:
- Shared package controlsgs_pkg holds typedef controlsgs_t as a packed struct. Field order, MSB first:
  - reg_write 1
  - mem_write 1
  - mem_read 1
  - mem_to_reg 1
  - alu_src 1
  - branch 1
  - jump 1
  - alu_op 3
- The same package holds localparam CTRL_NOP = '0.
- The file controlsgs.sv provides this package/typedef and is shared by all pipeline registers.
- One natural sub-module is pipe_reg #(WIDTH): a flop vector with async active-low reset, synchronous clear and enable. Instantiate it once per field, or once on the concatenated bundle.

Test Plan:
- Hold reset = 0 with e_alu_y = 32'h000000A1 and enable = 1 -> m_alu_y = 0 and m_controlsgs = 0 for every clock while reset is low.
- Release reset; enable = 1, e_alu_y = 32'h000000A1, e_controlsgs = all fields 1 with alu_op = 3'b101 -> after one rising edge, m_alu_y = 32'hA1 and m_controlsgs equals the input bit-for-bit.
- Capture 32'hA1, then set enable = 0 and e_alu_y = 32'hDEADBEEF for 3 edges -> m_alu_y stays 32'hA1. Set enable = 1 -> next edge gives 32'hDEADBEEF.
- flush = 1 and enable = 1 with non-zero inputs -> next edge: all m_* = 0, m_controlsgs.reg_write = 0, mem_write = 0. With flush = 1, enable = 0 -> also zeros.
- Assert reset low between clock edges while outputs are non-zero -> outputs go to 0 before the next edge.
- With EX_DM_VALID_EN defined: e_valid = 0, enable = 1, e_controlsgs all ones -> m_valid = 0 and m_controlsgs = 0.
